data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side end of the data memory address path: accepts the 16-bit address DMADDR driven by the address register, plus read/write strobes and write data.
- Performs a single-word access against an internal word array with a fixed, parameterised latency, then signals completion with DONE.
- Sits between the core's AR/DR registers and the data memory array. One instance per core port.

Parameters:
- DEPTH, 256, number of 16-bit words implemented; legal addresses are 0..DEPTH-1.
- LAT, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the posedge.
- rst_n  input  1  asynchronous, active-low reset.
- DMADDR  input  16  word address from the address register.
- DMDIN  input  16  write data from the data register.
- RD  input  1  read request, sampled only in IDLE.
- WR  input  1  write request, sampled only in IDLE.
- DMDOUT  output  16  read data; holds the last completed read.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  one-cycle pulse, coincident with DONE, for an out-of-range address.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; counter=0; latched address and data cleared.
  - DMDOUT=0, BUSY=0, DONE=0, ERR=0.
  - Array contents are not cleared and are undefined until written.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a posedge with RD=1 or WR=1, latch DMADDR, DMDIN and the op, load counter=LAT-1, go to WAIT.
  - Write priority: RD=1 and WR=1 together is treated as a write.
  - RD=0 and WR=0: stay in IDLE.
- WAIT:
  - Counter decrements each posedge.
  - On the posedge where counter==0, go to DONE and perform the access at that same edge:
    - read: DMDOUT <= array[addr];
    - write: array[addr] <= data; DMDOUT unchanged.
  - RD, WR, DMADDR and DMDIN are ignored throughout WAIT. Only the latched copies are used.
- DONE:
  - DONE=1 for exactly one cycle, then return to IDLE unconditionally.
  - Requests during the DONE cycle are ignored.
- Latency: request sampled at edge E0 → access performed at edge E0+LAT → DONE high in the cycle after E0+LAT → earliest next acceptance at edge E0+LAT+2.
- BUSY: 1 from the cycle after E0 through the DONE cycle inclusive.
- Out-of-range address (latched addr >= DEPTH):
  - No array access; a write is dropped.
  - A read sets DMDOUT <= 0.
  - ERR=1 together with DONE.
- Address decode: full 16-bit compare against DEPTH; no aliasing or wrap-around.
- Reset mid-operation: an access in WAIT is aborted and a pending write is never committed. DONE/ERR are cleared immediately.
- Back-to-back: RD held high continuously gives one access every LAT+2 cycles.

Decomposition:
- Shared package dm_pkg:
  - constants DM_DATA_W=16, DM_ADDR_W=16;
  - state enum dm_state_t {IDLE, WAIT, DONE};
  - op enum dm_op_t {OP_RD, OP_WR}.
- Sub-module dm_array:
  - synchronous single-port RAM, DEPTH x 16;
  - inputs: clk, en, we, addr, wdata; output: rdata;
  - no reset.
- The FSM, counter, range check and output registers live in data_memory_responder.

Test Plan:
- Reset check: drive rst_n=0 asynchronously mid-cycle → DMDOUT=0x0000, BUSY=0, DONE=0, ERR=0 immediately, without waiting for a clock edge.
- Write/read round-trip, LAT=2:
  - write 0xBEEF to address 0x0010 at E0 → DONE pulses in the cycle after E0+2;
  - then read 0x0010 → DMDOUT=0xBEEF in the DONE cycle;
  - BUSY is high for exactly 3 cycles per access.
- Out-of-range, DEPTH=256:
  - write 0x1234 to 0x0100 → DONE=1 and ERR=1; array unchanged;
  - read 0x0100 → DMDOUT=0x0000, ERR=1;
  - read 0x00FF → valid data, ERR=0.
- Ignored inputs: accept a read of 0x0005 (contents 0x00AA), then change DMADDR to 0x0006 and assert WR during WAIT → DMDOUT=0x00AA, and address 0x0006 is not written.
- Simultaneous RD=WR=1 with DMADDR=0x0020, DMDIN=0x5A5A → treated as a write; DMDOUT unchanged; a subsequent read of 0x0020 returns 0x5A5A.
- Abort: start a write of 0xFFFF to 0x0030 over old contents 0x0001, then pulse rst_n low during WAIT → no DONE; a following read of 0x0030 returns 0x0001.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and widths for the data memory responder.
// Provides the data/address widths, the FSM state enum and the latched op enum.
package dm_pkg;

    localparam int unsigned DM_DATA_W = 16;
    localparam int unsigned DM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dm_op_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Core-to-memory handshake bundle for one data memory port.
// master: core side (drives address, write data, strobes)
// slave : memory responder (drives read data, BUSY, DONE, ERR)
interface data_memory_responder_if;
    import dm_pkg::*;

    logic [DM_ADDR_W-1:0] DMADDR;
    logic [DM_DATA_W-1:0] DMDIN;
    logic                 RD;
    logic                 WR;
    logic [DM_DATA_W-1:0] DMDOUT;
    logic                 BUSY;
    logic                 DONE;
    logic                 ERR;

    modport master (
        output DMADDR, DMDIN, RD, WR,
        input  DMDOUT, BUSY, DONE, ERR
    );

    modport slave (
        input  DMADDR, DMDIN, RD, WR,
        output DMDOUT, BUSY, DONE, ERR
    );

endinterface

// File: rtl/dm_array.sv
// Synchronous single-port word RAM, DEPTH x DM_DATA_W, no reset.
// Ports: clk, en (access enable), we (write when en), addr, wdata,
//        rdata (registered, updates only on an enabled read).
module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [DM_DATA_W-1:0] wdata,
    output logic [DM_DATA_W-1:0] rdata
);

    logic [DM_DATA_W-1:0] mem [DEPTH];

    // Single port: one read or one write per enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the data memory address path.
// Accepts a read/write request in IDLE, waits LAT cycles, performs one word
// access against dm_array and pulses DONE (with ERR for out-of-range addresses).
// Ports: clk, rst_n (async active-low), bus (slave modport: DMADDR, DMDIN,
//        RD, WR in; DMDOUT, BUSY, DONE, ERR out, all registered).
module data_memory_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

    dm_state_t            state_q, state_d;
    dm_op_t               op_q, op_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DM_ADDR_W-1:0] addr_q, addr_d;
    logic [DM_DATA_W-1:0] data_q, data_d;
    logic [DM_DATA_W-1:0] dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DM_DATA_W-1:0] ram_rdata;
    logic                 addr_ok_c;
    logic                 req_addr_ok_c;

    // Full-width range checks; no aliasing of high addresses.
    assign addr_ok_c     = 32'(addr_q) < DEPTH;
    assign req_addr_ok_c = 32'(bus.DMADDR) < DEPTH;

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Next-state and output logic. The RAM read is issued one edge before the
    // access edge so its registered rdata can be captured into DMDOUT exactly
    // at the access edge.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = AW'(addr_q);

        case (state_q)
            IDLE: begin
                if (bus.RD || bus.WR) begin
                    addr_d  = bus.DMADDR;
                    data_d  = bus.DMDIN;
                    op_d    = bus.WR ? OP_WR : OP_RD;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                    // With LAT=1 the pre-access edge is the accept edge itself.
                    if (LAT == 1 && !bus.WR && req_addr_ok_c) begin
                        ram_en   = 1'b1;
                        ram_addr = AW'(bus.DMADDR);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = !addr_ok_c;
                    if (op_q == OP_RD) begin
                        dout_d = addr_ok_c ? ram_rdata : '0;
                    end else if (addr_ok_c) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1 && op_q == OP_RD && addr_ok_c) begin
                        ram_en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.DMDOUT = dout_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.ERR    = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (DEPTH=256, LAT=2).
// A transaction-timeline model predicts BUSY/DONE/ERR/DMDOUT every cycle;
// directed transfers add hand-computed literal expectations.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    data_memory_responder_if bus();

    data_memory_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a request accepted at edge n is accessed at edge n+LAT,
    // DONE is visible after that edge, and the port is free again at n+LAT+2.
    logic [15:0] mmem [int];
    logic [15:0] m_dout = '0;
    bit          m_busy = 0, m_done = 0, m_err = 0;
    bit          m_active = 0;
    bit          m_wr = 0;
    logic [15:0] m_addr = '0, m_data = '0;
    int          cyc = 0, m_acc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_dout = '0; m_busy = 0; m_done = 0; m_err = 0; m_active = 0;
            end else begin
                cyc++;
                m_done = 0;
                m_err  = 0;
                if (m_active) begin
                    if (cyc == m_acc + 1) begin
                        m_active = 0;
                    end else if (cyc == m_acc) begin
                        m_done = 1;
                        m_err  = (m_addr >= DEPTH);
                        if (m_wr) begin
                            if (!m_err) mmem[int'(m_addr)] = m_data;
                        end else begin
                            m_dout = m_err ? 16'h0000 : mmem[int'(m_addr)];
                        end
                    end
                end else if (bus.RD || bus.WR) begin
                    m_active = 1;
                    m_wr     = bus.WR;
                    m_addr   = bus.DMADDR;
                    m_data   = bus.DMDIN;
                    m_acc    = cyc + LAT;
                end
                m_busy = m_active;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_busy",   16'(bus.BUSY),   16'(m_busy));
                chk("cyc_done",   16'(bus.DONE),   16'(m_done));
                chk("cyc_err",    16'(bus.ERR),    16'(m_err));
                chk("cyc_dmdout", bus.DMDOUT,      m_dout);
            end
        end
    end

    // One request; optionally disturb the inputs during WAIT. Returns the
    // DMDOUT/ERR seen in the DONE cycle and the number of BUSY cycles.
    task automatic xfer(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input bit mess,
                        output logic [15:0] dout, output logic err, output int busy_n);
        bit seen = 0;
        busy_n = 0; dout = '0; err = 1'b0;
        @(negedge clk);
        bus.RD = rd; bus.WR = wr; bus.DMADDR = a; bus.DMDIN = d;
        @(negedge clk);
        bus.RD = 1'b0; bus.WR = 1'b0;
        if (mess) begin
            bus.DMADDR = 16'h0006; bus.DMDIN = 16'hDEAD; bus.WR = 1'b1;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                seen = 1; dout = bus.DMDOUT; err = bus.ERR; bus.WR = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("done_seen", 16'(seen), 16'd1);
        bus.WR = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 16'(bus.DONE), 16'd0);
        chk("busy_after_done", 16'(bus.BUSY), 16'd0);
    endtask

    logic [15:0] dout;
    logic        err;
    int          busy_n;
    int          n_done;

    initial begin
        bus.RD = 1'b0; bus.WR = 1'b0; bus.DMADDR = '0; bus.DMDIN = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_dmdout", bus.DMDOUT, 16'h0000);
        chk("rst_busy", 16'(bus.BUSY), 16'd0);
        #18 rst_n = 1'b1;
        chk_en = 1'b1;

        // Write/read round trip
        xfer(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, dout, err, busy_n);
        chk("wr_busy_cycles", 16'(busy_n), 16'd3);
        chk("wr_err", 16'(err), 16'd0);
        xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 0, dout, err, busy_n);
        chk("rd_beef", dout, 16'hBEEF);
        chk("rd_busy_cycles", 16'(busy_n), 16'd3);

        // Out of range: no aliasing onto 0x0000, reads give zero
        xfer(1'b0, 1'b1, 16'h0000, 16'h0C0C, 0, dout, err, busy_n);
        xfer(1'b0, 1'b1, 16'h00FF, 16'h0FF0, 0, dout, err, busy_n);
        xfer(1'b0, 1'b1, 16'h0100, 16'h1234, 0, dout, err, busy_n);
        chk("oor_wr_err", 16'(err), 16'd1);
        xfer(1'b1, 1'b0, 16'h0100, 16'h0000, 0, dout, err, busy_n);
        chk("oor_rd_data", dout, 16'h0000);
        chk("oor_rd_err", 16'(err), 16'd1);
        xfer(1'b1, 1'b0, 16'h00FF, 16'h0000, 0, dout, err, busy_n);
        chk("top_rd_data", dout, 16'h0FF0);
        chk("top_rd_err", 16'(err), 16'd0);
        xfer(1'b1, 1'b0, 16'h0000, 16'h0000, 0, dout, err, busy_n);
        chk("no_alias_0", dout, 16'h0C0C);
        xfer(1'b1, 1'b0, 16'h8010, 16'h0000, 0, dout, err, busy_n);
        chk("oor_high_err", 16'(err), 16'd1);

        // Inputs ignored during WAIT
        xfer(1'b0, 1'b1, 16'h0005, 16'h00AA, 0, dout, err, busy_n);
        xfer(1'b0, 1'b1, 16'h0006, 16'h0066, 0, dout, err, busy_n);
        xfer(1'b1, 1'b0, 16'h0005, 16'h0000, 1, dout, err, busy_n);
        chk("ign_rd_data", dout, 16'h00AA);
        xfer(1'b1, 1'b0, 16'h0006, 16'h0000, 0, dout, err, busy_n);
        chk("ign_not_written", dout, 16'h0066);

        // RD and WR together is a write
        xfer(1'b1, 1'b1, 16'h0020, 16'h5A5A, 0, dout, err, busy_n);
        chk("rdwr_dout_held", dout, 16'h0066);
        xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 0, dout, err, busy_n);
        chk("rdwr_readback", dout, 16'h5A5A);

        // Back-to-back reads: one access every LAT+2 cycles
        n_done = 0;
        @(negedge clk);
        bus.RD = 1'b1; bus.DMADDR = 16'h0010;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.DONE) n_done++;
        end
        bus.RD = 1'b0;
        chk("b2b_done_count", 16'(n_done), 16'd4);
        chk("b2b_dout", bus.DMDOUT, 16'hBEEF);
        repeat (6) @(negedge clk);

        // Abort a write with a mid-cycle reset
        xfer(1'b0, 1'b1, 16'h0030, 16'h0001, 0, dout, err, busy_n);
        @(negedge clk);
        bus.WR = 1'b1; bus.DMADDR = 16'h0030; bus.DMDIN = 16'hFFFF;
        @(posedge clk);
        #1 bus.WR = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dmdout", bus.DMDOUT, 16'h0000);
        chk("abort_busy", 16'(bus.BUSY), 16'd0);
        chk("abort_done", 16'(bus.DONE), 16'd0);
        chk("abort_err", 16'(bus.ERR), 16'd0);
        #2 rst_n = 1'b1;
        n_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.DONE) n_done++;
        end
        chk("abort_no_done", 16'(n_done), 16'd0);
        xfer(1'b1, 1'b0, 16'h0030, 16'h0000, 0, dout, err, busy_n);
        chk("abort_old_data", dout, 16'h0001);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
